cpu_program_loader: RTL
=======================

# cpu_program_loader

Host-side loader sitting directly upstream of the `cpu` top; it drives the CPU's external memory ports and its `enable` input. It streams a program image from a valid/ready host channel into instruction memory, then an initial data image into data memory. It then enables the CPU for a programmed number of cycles and streams the data-memory contents back out on a second valid/ready channel. The CPU's own reset is not driven by this block.

## Interface
- IMEM_WORDS, 512: instruction memory depth in 32-bit words.
- DMEM_WORDS, 1024: data memory depth in 64-bit words.

- clk  in  1  clock
- arst  in  1  asynchronous reset, active-high
- start  in  1  single-cycle request; sampled only in IDLE or DONE
- imem_len  in  10  instruction words to load, legal range 0..IMEM_WORDS
- dmem_len  in  11  data words to load and later dump, legal range 0..DMEM_WORDS
- run_cycles  in  32  number of cycles `cpu_enable` is held high
- s_valid / s_ready  in / out  1  host input handshake
- s_data  in  64  input word; only [31:0] is used during the instruction phase
- addr_ext, wen_ext, ren_ext, wdata_ext  out  64/1/1/32  to the CPU instruction-memory external port
- addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2  out  64/1/1/64  to the CPU data-memory external port
- rdata_ext_2  in  64  data-memory read data
- cpu_enable  out  1  drives the CPU `enable` input
- m_valid / m_ready  out / in  1  dump output handshake
- m_data  out  64  dump word
- busy, done, err  out  1  status flags

## Operation
- States: IDLE, LOAD_I, LOAD_D, RUN, RD_REQ, RD_WAIT, DUMP, DONE.
- A `start` in IDLE/DONE latches imem_len, dmem_len and run_cycles, and clears the word counter and `err`.
- Range check on `start`: if imem_len > IMEM_WORDS or dmem_len > DMEM_WORDS, go directly to DONE with err=1. No memory access and no enable occur.
- LOAD_I:
  - s_ready=1.
  - Each accepted word i (s_valid&&s_ready) produces a write to instruction memory: addr_ext=4*i, wdata_ext=s_data[31:0].
  - After imem_len words, go to LOAD_D. If imem_len=0, the state is skipped.
- LOAD_D: as LOAD_I, but each accepted word j writes data memory at addr_ext_2=8*j with wdata_ext_2=s_data. After dmem_len words (or 0), go to RUN.
- RUN:
  - s_ready=0 and cpu_enable=1 for exactly run_cycles cycles, counted by a 32-bit down-counter.
  - If run_cycles=0, go straight to the dump phase.
- RD_REQ: ren_ext_2=1 with addr_ext_2=8*k.
- RD_WAIT: rdata_ext_2 is valid this cycle (1-cycle SRAM latency). Capture it into m_data.
- DUMP: m_valid=1 with m_data held stable until m_ready. Then k++. Return to RD_REQ, or go to DONE after dmem_len words. If dmem_len=0, the dump phase is skipped.
- DONE: done=1 until the next `start`.
- busy=1 in every state except IDLE and DONE.
- Every start is a full load/run/dump sequence; there is no partial or skip mode other than zero lengths.

## Timing
- Reset values: state=IDLE; all strobes, addresses and data outputs 0; cpu_enable=0; s_ready=0; m_valid=0; busy=done=err=0.
- All outputs are registered.
- A handshake at edge n produces wen_ext/wen_ext_2 high for exactly one cycle after edge n, with address and data aligned in that same cycle.
- Load throughput: one word per cycle under continuous s_valid.
- Phase transitions:
  - The last LOAD_I handshake goes to LOAD_D on the next edge. s_ready stays 1, so there is no bubble.
  - The last LOAD_D handshake goes to RUN. The final write strobe is issued in the first RUN cycle, concurrently with cpu_enable.
- cpu_enable rises on the edge entering RUN and falls exactly run_cycles cycles later.
- Dump throughput: one word per 3 cycles (RD_REQ, RD_WAIT, DUMP) with m_ready held high.
- `start` while busy=1 is ignored.
- arst mid-operation returns to IDLE immediately and drops cpu_enable and all strobes. Memory contents are left as-is.
- Word indices never wrap, because the range check bounds the counters.
- ren_ext and wen_ext are never both asserted; ren_ext stays 0 always.

## Test plan
- Basic load: imem_len=3, dmem_len=0, run_cycles=0, with words 0x11,0x22,0x33. Expect three wen_ext pulses at addr 0,4,8 with those data values, then done=1 with no dumped words.
- Throttled input: dmem_len=2 with s_valid toggling every other cycle. Expect wen_ext_2 only after each handshake, at addr 0 and 8, with data matching.
- Run window: run_cycles=5. Expect cpu_enable high for exactly 5 consecutive cycles, and s_ready=0 throughout.
- Dump with backpressure: data memory pre-filled with 0xA,0xB, dmem_len=2, m_ready held low for 4 cycles. Expect m_valid held with m_data=0xA stable, then 0xA and 0xB emitted in order, then done=1.
- Range error: imem_len=513. Expect err=1 and done=1 within 1 cycle, with no strobes and cpu_enable=0.
- Reset abort: assert arst during RUN. Expect cpu_enable=0 and state IDLE immediately; a following start must run a clean full sequence.

Source files
------------

// File: rtl/cpu_program_loader.sv
// Host-side loader for the cpu: streams instruction and data images into memory,
// runs the cpu for a programmed number of cycles, then dumps data memory back out.
module cpu_program_loader #(
  parameter int IMEM_WORDS = 512,
  parameter int DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        start,
  input  logic [9:0]  imem_len,
  input  logic [10:0] dmem_len,
  input  logic [31:0] run_cycles,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [63:0] s_data,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2,
  output logic        cpu_enable,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [63:0] m_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE, LOAD_I, LOAD_D, RUN, RD_REQ, RD_WAIT, DUMP, DONE
  } state_t;

  state_t      state, state_next;
  logic [10:0] cnt, cnt_next;
  logic [31:0] rc, rc_next;
  logic [9:0]  imem_len_q;
  logic [10:0] dmem_len_q;
  logic [31:0] run_cycles_q;
  logic        s_hs, m_hs, start_ok, range_bad;

  assign ren_ext = 1'b0;

  always_comb begin
    s_hs      = s_valid && s_ready;
    m_hs      = m_valid && m_ready;
    start_ok  = start && (state == IDLE || state == DONE);
    range_bad = ({22'd0, imem_len} > 32'(IMEM_WORDS)) ||
                ({21'd0, dmem_len} > 32'(DMEM_WORDS));
  end

  // RUN is always visited after loading (for at least one cycle) so the final
  // data-memory write never collides with the first dump read.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    rc_next    = rc;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          cnt_next = 11'd0;
          rc_next  = run_cycles;
          if (range_bad)              state_next = DONE;
          else if (imem_len != 10'd0) state_next = LOAD_I;
          else if (dmem_len != 11'd0) state_next = LOAD_D;
          else                        state_next = RUN;
        end
      end
      LOAD_I: begin
        if (s_hs) begin
          if (cnt == {1'b0, imem_len_q} - 11'd1) begin
            cnt_next   = 11'd0;
            rc_next    = run_cycles_q;
            state_next = (dmem_len_q != 11'd0) ? LOAD_D : RUN;
          end else begin
            cnt_next = cnt + 11'd1;
          end
        end
      end
      LOAD_D: begin
        if (s_hs) begin
          if (cnt == dmem_len_q - 11'd1) begin
            cnt_next   = 11'd0;
            rc_next    = run_cycles_q;
            state_next = RUN;
          end else begin
            cnt_next = cnt + 11'd1;
          end
        end
      end
      RUN: begin
        if (rc <= 32'd1) begin
          cnt_next   = 11'd0;
          rc_next    = 32'd0;
          state_next = (dmem_len_q != 11'd0) ? RD_REQ : DONE;
        end else begin
          rc_next = rc - 32'd1;
        end
      end
      RD_REQ:  state_next = RD_WAIT;
      RD_WAIT: state_next = DUMP;
      DUMP: begin
        if (m_hs) begin
          if (cnt == dmem_len_q - 11'd1) begin
            state_next = DONE;
          end else begin
            cnt_next   = cnt + 11'd1;
            state_next = RD_REQ;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state        <= IDLE;
      cnt          <= 11'd0;
      rc           <= 32'd0;
      imem_len_q   <= 10'd0;
      dmem_len_q   <= 11'd0;
      run_cycles_q <= 32'd0;
      err          <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      rc    <= rc_next;
      if (start_ok) begin
        imem_len_q   <= imem_len;
        dmem_len_q   <= dmem_len;
        run_cycles_q <= run_cycles;
        err          <= range_bad;
      end
    end
  end

  // Outputs are registered from the next state so they line up with the state.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      s_ready     <= 1'b0;
      addr_ext    <= 64'd0;
      wen_ext     <= 1'b0;
      wdata_ext   <= 32'd0;
      addr_ext_2  <= 64'd0;
      wen_ext_2   <= 1'b0;
      ren_ext_2   <= 1'b0;
      wdata_ext_2 <= 64'd0;
      cpu_enable  <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= 64'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      s_ready    <= (state_next == LOAD_I) || (state_next == LOAD_D);
      wen_ext    <= s_hs && (state == LOAD_I);
      wen_ext_2  <= s_hs && (state == LOAD_D);
      ren_ext_2  <= (state_next == RD_REQ);
      cpu_enable <= (state_next == RUN) && (rc_next != 32'd0);
      m_valid    <= (state_next == DUMP);
      busy       <= (state_next != IDLE) && (state_next != DONE);
      done       <= (state_next == DONE);
      if (s_hs && state == LOAD_I) begin
        addr_ext  <= {51'd0, cnt, 2'b00};
        wdata_ext <= s_data[31:0];
      end
      if (s_hs && state == LOAD_D) begin
        addr_ext_2  <= {50'd0, cnt, 3'b000};
        wdata_ext_2 <= s_data;
      end else if (state_next == RD_REQ) begin
        addr_ext_2 <= {50'd0, cnt_next, 3'b000};
      end
      if (state == RD_WAIT) m_data <= rdata_ext_2;
    end
  end

endmodule
